uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
- Runtime-configurable UART transmitter; successor to the fixed-format TX in the UART IP.
- Accepts one parallel word over a valid/ready handshake and latches it with a per-frame format snapshot.
- Serialises start, 5..DATA_WD_MAX data bits (LSB first), optional parity, and 1/1.5/2 stop bits.
- Bit timing comes from an external oversampling tick supplied by the baud generator.

Parameters:
OVERSAMPLING, 16, ticks per bit; even, >=4
DATA_WD_MAX, 9, widest data field supported; 5..9

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-clk pulse at BAUD*OVERSAMPLING from the baud generator
tx_valid  in  1  word available
tx_data  in  DATA_WD_MAX  word; bits above the configured length are ignored
tx_ready  out  1  block can accept a word
cfg_data_len  in  4  data bits per frame, 5..DATA_WD_MAX
cfg_parity  in  3  0 none, 1 odd, 2 even, 3 mark(1), 4 space(0)
cfg_stop  in  2  0 one, 1 one-and-half, 2 two stop bits
tx  out  1  serial line, idle high
tx_busy  out  1  frame in progress
tx_done  out  1  one-clk pulse at end of frame

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: tx=1, tx_busy=0, tx_done=0, tx_ready=1 (state IDLE), all counters 0.
- Reset mid-frame: tx returns to 1 immediately and asynchronously. The frame is abandoned and no tx_done is produced.
- tx_ready: combinational, equal to (state==IDLE).
- Accept: occurs on the clk edge where tx_valid && tx_ready. At that edge the block latches tx_data, cfg_data_len, cfg_parity and cfg_stop. Config changes during a frame have no effect on it.
- Config sanitising at latch:
  - data_len <5 becomes 5; data_len >DATA_WD_MAX becomes DATA_WD_MAX.
  - cfg_parity 5..7 becomes none.
  - cfg_stop 3 becomes two stop bits.
- Parity bit values:
  - odd: ~^data
  - even: ^data
  - mark: 1
  - space: 0
  - Only the latched data_len bits enter the parity calculation.
- State machine (one-hot): IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after OVERSAMPLING ticks.
  - DATA -> PARITY, or -> STOP if parity is none, after data_len bit periods.
  - PARITY -> STOP after OVERSAMPLING ticks.
  - STOP -> IDLE after the stop length in ticks: OVERSAMPLING, OVERSAMPLING*3/2, or 2*OVERSAMPLING.
- tx is registered.
  - tx goes to 0 on the first clk after accept; the START duration counts from that cycle.
  - Each bit holds for exactly OVERSAMPLING tick pulses.
  - The tick counter advances only on tick=1, and the bit index advances when the counter wraps.
  - With tick held at 0, the line and all counters freeze.
- Tick counter width: clog2(2*OVERSAMPLING), so two stop bits are counted in one span. Bit index width: clog2(DATA_WD_MAX+1).
- tx_busy: 1 from the cycle after accept through the last STOP cycle, 0 in IDLE.
- tx_done: 1 for exactly one clk, on the first IDLE cycle after STOP.
  - tx_ready is also 1 in that cycle, so a back-to-back accept is legal there.
  - With a back-to-back accept, the next start bit begins one clk after the previous stop period ends; there is no extra idle bit.
- Ticks arriving in IDLE are ignored; the counter is held at 0 in IDLE.

Decomposition:
- Package uart_pkg:
  - parity-mode encodings: PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK, PAR_SPACE
  - stop encodings: STOP_1, STOP_1P5, STOP_2
  - one-hot state localparams
  - helper function for stop length in ticks
- One sub-module: uart_parity_gen, a combinational block.
  - Inputs: masked data and the latched parity mode.
  - Output: the parity bit.
  - The RX successor reuses it for its parity check.

Test Plan (all with OVERSAMPLING=16, tick=1 every clk unless stated):
1. 8N1, tx_data=0x55 -> tx: 0 for 16 clks, then 1,0,1,0,1,0,1,0 each 16 clks, then 1 for 16 clks. tx_done pulses once at clk 161 after accept.
2. 7-bit odd parity, tx_data=0x03 -> parity bit=1. 7E2 with tx_data=0x07 -> parity bit=1, stop high for 32 clks. Frame is 176 clks.
3. 5N1.5 with tx_data=0x1F plus an illegal cfg_data_len=2 on a second frame -> stop high 24 clks. The second frame is sent as 5 bits.
4. Two back-to-back words (tx_valid held high, 0xA5 then 0x3C) -> second start bit begins exactly one clk after the first stop ends. tx_ready is high for 1 clk between frames.
5. tick asserted every 4th clk, and cfg changed mid-frame -> each bit lasts 64 clks. The frame format is unchanged.
6. rst_n low during DATA bit 3 -> tx=1, tx_busy=0 immediately with no tx_done. After release, tx_ready=1 and a new frame completes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the configurable UART transmitter
// and its receive-side companion.
package uart_pkg;

  // Parity modes as presented on cfg_parity
  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_ODD   = 3'd1,
    PAR_EVEN  = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } par_mode_t;

  // Stop-bit lengths as presented on cfg_stop
  typedef enum logic [1:0] {
    STOP_1   = 2'd0,
    STOP_1P5 = 2'd1,
    STOP_2   = 2'd2
  } stop_mode_t;

  // One-hot transmitter states
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } tx_state_t;

  // Length of the stop period in oversampling ticks
  function automatic int stop_ticks(input stop_mode_t mode, input int os);
    case (mode)
      STOP_1:   return os;
      STOP_1P5: return (os * 3) / 2;
      default:  return 2 * os;
    endcase
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity bit generator; expects data already masked to the
// active frame length so unused upper bits contribute nothing.
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] data,
  input  par_mode_t        mode,
  output logic             parity
);

  // Select the parity value for the requested mode
  always_comb begin
    parity = 1'b0;
    case (mode)
      PAR_ODD:  parity = ~^data;
      PAR_EVEN: parity = ^data;
      PAR_MARK: parity = 1'b1;
      default:  parity = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter. A word and its frame format are
// snapshotted at accept; the frame is then paced by the external
// oversampling tick.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int OVERSAMPLING = 16,
  parameter int DATA_WD_MAX  = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   tx_valid,
  input  logic [DATA_WD_MAX-1:0] tx_data,
  output logic                   tx_ready,
  input  logic [3:0]             cfg_data_len,
  input  logic [2:0]             cfg_parity,
  input  logic [1:0]             cfg_stop,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   tx_done
);

  localparam int CW = $clog2(2 * OVERSAMPLING);
  localparam int BW = $clog2(DATA_WD_MAX + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(OVERSAMPLING - 1);

  tx_state_t              state;
  logic [CW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_WD_MAX-1:0] shift_reg;
  logic [3:0]             len_reg;
  logic                   has_parity;
  logic                   parity_bit;
  stop_mode_t             stop_reg;

  logic [3:0]             len_sel;
  par_mode_t              par_sel;
  stop_mode_t             stop_sel;
  logic [DATA_WD_MAX-1:0] data_mask;
  logic [DATA_WD_MAX-1:0] data_sel;
  logic                   par_bit_sel;
  logic [CW-1:0]          stop_last;
  logic [BW-1:0]          bit_last;

  assign tx_ready  = (state == ST_IDLE);
  assign stop_last = CW'(stop_ticks(stop_reg, OVERSAMPLING) - 1);
  assign bit_last  = BW'(len_reg - 4'd1);

  // Clamp the incoming format to legal values and mask the word to its length
  always_comb begin
    len_sel = cfg_data_len;
    if (cfg_data_len < 4'd5)
      len_sel = 4'd5;
    else if (32'(cfg_data_len) > DATA_WD_MAX)
      len_sel = 4'(DATA_WD_MAX);

    par_sel  = (cfg_parity > 3'd4) ? PAR_NONE : par_mode_t'(cfg_parity);
    stop_sel = (cfg_stop == 2'd3) ? STOP_2 : stop_mode_t'(cfg_stop);

    data_mask = '0;
    for (int i = 0; i < DATA_WD_MAX; i++)
      data_mask[i] = (i < 32'(len_sel));
    data_sel = tx_data & data_mask;
  end

  // Parity is computed from the word being accepted and stored with it
  uart_parity_gen #(
    .WIDTH (DATA_WD_MAX)
  ) u_parity (
    .data   (data_sel),
    .mode   (par_sel),
    .parity (par_bit_sel)
  );

  // Frame sequencer: all bit timing advances only on tick pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      len_reg    <= 4'd5;
      has_parity <= 1'b0;
      parity_bit <= 1'b0;
      stop_reg   <= STOP_1;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tick_cnt <= '0;
          bit_idx  <= '0;
          tx       <= 1'b1;
          if (tx_valid) begin
            shift_reg  <= data_sel;
            len_reg    <= len_sel;
            has_parity <= (par_sel != PAR_NONE);
            parity_bit <= par_bit_sel;
            stop_reg   <= stop_sel;
            state      <= ST_START;
            tx         <= 1'b0;
            tx_busy    <= 1'b1;
          end
        end

        ST_START: begin
          if (tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              state    <= ST_DATA;
              tx       <= shift_reg[0];
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              if (bit_idx == bit_last) begin
                bit_idx <= '0;
                if (has_parity) begin
                  state <= ST_PARITY;
                  tx    <= parity_bit;
                end else begin
                  state <= ST_STOP;
                  tx    <= 1'b1;
                end
              end else begin
                bit_idx   <= bit_idx + BW'(1);
                shift_reg <= shift_reg >> 1;
                tx        <= shift_reg[1];
              end
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end

        ST_PARITY: begin
          if (tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              state    <= ST_STOP;
              tx       <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (tick_cnt == stop_last) begin
              tick_cnt <= '0;
              state    <= ST_IDLE;
              tx       <= 1'b1;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end

        default: begin
          state    <= ST_IDLE;
          tick_cnt <= '0;
          bit_idx  <= '0;
          tx       <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg.
module tb_uart_tx_cfg;

  localparam int OS = 16;
  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic [3:0]    cfg_data_len = 4'd8;
  logic [2:0]    cfg_parity = 3'd0;
  logic [1:0]    cfg_stop = 2'd0;
  logic          tx_ready;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;

  int total = 0;
  int bad = 0;
  int tick_div = 1;
  int tick_phase = 0;

  uart_tx_cfg #(
    .OVERSAMPLING (OS),
    .DATA_WD_MAX  (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .cfg_data_len (cfg_data_len),
    .cfg_parity   (cfg_parity),
    .cfg_stop     (cfg_stop),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  // Tick generator: updated shortly after each rising edge, once every tick_div clocks
  always @(posedge clk) begin
    #2;
    if (tick_div <= 1) begin
      tick = 1'b1;
    end else begin
      tick_phase = (tick_phase + 1) % tick_div;
      tick = (tick_phase == 0);
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it, and report observed/expected on mismatch
  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present a word and format at a falling edge; the next rising edge accepts it
  task automatic apply_stimulus(input logic [8:0] data, input logic [3:0] len,
                                input logic [2:0] par, input logic [1:0] stop, input bit hold);
    check_output("ready before accept", {31'd0, tx_ready}, 32'd1);
    tx_data      = data;
    cfg_data_len = len;
    cfg_parity   = par;
    cfg_stop     = stop;
    tx_valid     = 1'b1;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
  endtask

  // Walk one frame cycle by cycle from the first cycle after accept.
  // bits[i] is the i-th transmitted bit (start, data LSB first, parity);
  // the stop period follows. Ends on the tx_done cycle.
  task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits,
                             input int stop_clks, input int bit_clks, input int chg_cycle);
    int held[0:11];
    int busy_cnt;
    int done_cnt;
    int ready_cnt;
    int frame_len;
    int seg;
    logic expv;
    for (int s = 0; s < 12; s++) held[s] = 0;
    busy_cnt  = 0;
    done_cnt  = 0;
    ready_cnt = 0;
    frame_len = nbits * bit_clks + stop_clks;
    for (int c = 0; c < frame_len; c++) begin
      seg = c / bit_clks;
      if (seg >= nbits) begin
        seg  = nbits;
        expv = 1'b1;
      end else begin
        expv = bits[seg];
      end
      if (tx === expv) held[seg]++;
      if (tx_busy === 1'b1) busy_cnt++;
      if (tx_done === 1'b1) done_cnt++;
      if (tx_ready === 1'b1) ready_cnt++;
      if (c == chg_cycle) begin
        cfg_data_len = 4'd5;
        cfg_parity   = 3'd2;
        cfg_stop     = 2'd1;
        tx_data      = 9'h1FF;
      end
      @(negedge clk);
    end
    for (int s = 0; s < nbits; s++)
      check_output($sformatf("%s bit%0d clks", tag, s), held[s], bit_clks);
    check_output($sformatf("%s stop clks", tag), held[nbits], stop_clks);
    check_output($sformatf("%s busy clks", tag), busy_cnt, frame_len);
    check_output($sformatf("%s done in frame", tag), done_cnt, 0);
    check_output($sformatf("%s ready in frame", tag), ready_cnt, 0);
    check_output($sformatf("%s done at end", tag), {31'd0, tx_done}, 32'd1);
    check_output($sformatf("%s line at end", tag), {31'd0, tx}, 32'd1);
    check_output($sformatf("%s busy at end", tag), {31'd0, tx_busy}, 32'd0);
    check_output($sformatf("%s ready at end", tag), {31'd0, tx_ready}, 32'd1);
  endtask

  initial begin
    int dseen;

    // Reset values, both during and after reset
    repeat (3) @(negedge clk);
    check_output("reset tx", {31'd0, tx}, 32'd1);
    check_output("reset busy", {31'd0, tx_busy}, 32'd0);
    check_output("reset done", {31'd0, tx_done}, 32'd0);
    check_output("reset ready", {31'd0, tx_ready}, 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output("idle tx", {31'd0, tx}, 32'd1);
    check_output("idle done", {31'd0, tx_done}, 32'd0);

    // 8N1, 0x55: bits 0,1,0,1,0,1,0,1,0 -> 0x0AA
    apply_stimulus(9'h055, 4'd8, 3'd0, 2'd0, 1'b0);
    check_frame("8N1", 16'h00AA, 9, 16, OS, -1);
    @(negedge clk);
    check_output("8N1 done single pulse", {31'd0, tx_done}, 32'd0);

    // 7O1, 0x03: even count of ones, odd parity bit 1 -> 0x106
    apply_stimulus(9'h003, 4'd7, 3'd1, 2'd0, 1'b0);
    check_frame("7O1", 16'h0106, 9, 16, OS, -1);
    @(negedge clk);

    // 7E2, 0x07: odd count of ones, even parity bit 1, 32-clk stop -> 0x10E
    apply_stimulus(9'h007, 4'd7, 3'd2, 2'd2, 1'b0);
    check_frame("7E2", 16'h010E, 9, 32, OS, -1);
    @(negedge clk);

    // 5N1.5, 0x1F: 24-clk stop -> 0x03E
    apply_stimulus(9'h01F, 4'd5, 3'd0, 2'd1, 1'b0);
    check_frame("5N1.5", 16'h003E, 6, 24, OS, -1);
    @(negedge clk);

    // len=2 clamps to 5 (0x0E3 -> 00011), parity 7 -> none, stop 3 -> two
    apply_stimulus(9'h0E3, 4'd2, 3'd7, 2'd3, 1'b0);
    check_frame("len2 clamp", 16'h0006, 6, 32, OS, -1);
    @(negedge clk);

    // len=15 clamps to 9, space parity: data 0x1A5 -> 0x34A over 11 bits
    apply_stimulus(9'h1A5, 4'd15, 3'd4, 2'd0, 1'b0);
    check_frame("len15 clamp", 16'h034A, 11, 16, OS, -1);
    @(negedge clk);

    // Back-to-back: valid held, 0xA5 then 0x3C
    apply_stimulus(9'h0A5, 4'd8, 3'd0, 2'd0, 1'b1);
    tx_data = 9'h03C;
    check_frame("b2b first", 16'h014A, 9, 16, OS, -1);
    @(negedge clk);
    tx_valid = 1'b0;
    check_frame("b2b second", 16'h0078, 9, 16, OS, -1);
    @(negedge clk);

    // Tick every 4th clock, accept aligned with a tick, format changed mid-frame
    tick_div = 4;
    for (int i = 0; i < 8 && tick !== 1'b1; i++) @(negedge clk);
    check_output("tick aligned", {31'd0, tick}, 32'd1);
    apply_stimulus(9'h096, 4'd8, 3'd0, 2'd0, 1'b0);
    check_frame("tick4", 16'h012C, 9, 64, 4 * OS, 200);
    tick_div = 1;
    repeat (2) @(negedge clk);

    // Reset during DATA bit 3 of 0xF0 (bit 3 is 0)
    apply_stimulus(9'h0F0, 4'd8, 3'd0, 2'd0, 1'b0);
    repeat (69) @(negedge clk);
    check_output("pre-reset line", {31'd0, tx}, 32'd0);
    check_output("pre-reset busy", {31'd0, tx_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async reset tx", {31'd0, tx}, 32'd1);
    check_output("async reset busy", {31'd0, tx_busy}, 32'd0);
    check_output("async reset ready", {31'd0, tx_ready}, 32'd1);
    dseen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) dseen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) dseen++;
    end
    check_output("no done after reset", dseen, 0);
    check_output("ready after reset", {31'd0, tx_ready}, 32'd1);

    // Fresh frame after reset: 8E1, 0x81 has even ones so parity 0 -> 0x102
    apply_stimulus(9'h081, 4'd8, 3'd2, 2'd0, 1'b0);
    check_frame("post-reset 8E1", 16'h0102, 10, 16, OS, -1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
